// File: rtl/calcula_distancias.sv
// Sum-of-absolute-differences engine: compares a frame of samples against 10 digit
// templates from a 1-cycle-latency ROM and publishes per-digit distances with a done pulse.
module calcula_distancias #(
    parameter int N_ELEM = 64,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16,
    parameter int ADDR_W = 6
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 inicio,
    input  logic [DATA_W-1:0]    amostra,
    input  logic                 amostra_valida,
    output logic                 amostra_pronta,
    output logic [ADDR_W-1:0]    template_addr,
    input  logic [10*DATA_W-1:0] template_dados,
    output logic [10*ACC_W-1:0]  diferencas,
    output logic                 pronto,
    output logic                 ocupado
);

    typedef enum logic [1:0] {IDLE, ACUMULA, DRENA, FIM} estado_t;

    localparam logic [ADDR_W-1:0] ULTIMO = ADDR_W'(N_ELEM - 1);

    estado_t              state_q, state_d;
    logic [ADDR_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]    amostra_q, amostra_d;
    logic                 pv_q, pv_d;
    logic [ACC_W-1:0]     acc_q [10];
    logic [ACC_W-1:0]     acc_d [10];
    logic [10*ACC_W-1:0]  dif_q, dif_d;
    logic                 pronto_q, pronto_d;

    // Saturating accumulate of |a - b|; the difference is zero-extended before the add.
    function automatic logic [ACC_W-1:0] soma_sat(input logic [ACC_W-1:0] acc,
                                                   input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] d;
        logic [ACC_W:0]    s;
        d = (a > b) ? (a - b) : (b - a);
        s = {1'b0, acc} + (ACC_W + 1)'(d);
        return s[ACC_W] ? '1 : s[ACC_W-1:0];
    endfunction

    assign template_addr  = cnt_q;
    assign amostra_pronta = (state_q == ACUMULA);
    assign ocupado        = (state_q != IDLE);
    assign diferencas     = dif_q;
    assign pronto         = pronto_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        amostra_d = amostra_q;
        pv_d      = 1'b0;
        acc_d     = acc_q;
        dif_d     = dif_q;
        pronto_d  = 1'b0;

        // Second pipeline stage: ROM data for the element accepted last edge is now valid.
        if (pv_q && (state_q == ACUMULA || state_q == DRENA)) begin
            for (int unsigned k = 0; k < 10; k++) begin
                acc_d[k] = soma_sat(acc_q[k], amostra_q, template_dados[k*DATA_W +: DATA_W]);
            end
        end

        case (state_q)
            IDLE: begin
                if (inicio) begin
                    for (int unsigned k = 0; k < 10; k++) begin
                        acc_d[k] = '0;
                    end
                    cnt_d   = '0;
                    state_d = ACUMULA;
                end
            end
            ACUMULA: begin
                if (amostra_valida) begin
                    amostra_d = amostra;
                    pv_d      = 1'b1;
                    if (cnt_q == ULTIMO) begin
                        state_d = DRENA;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DRENA: begin
                state_d = FIM;
            end
            FIM: begin
                for (int unsigned k = 0; k < 10; k++) begin
                    dif_d[k*ACC_W +: ACC_W] = acc_q[k];
                end
                pronto_d = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            amostra_q <= '0;
            pv_q      <= 1'b0;
            for (int unsigned k = 0; k < 10; k++) begin
                acc_q[k] <= '0;
            end
            dif_q     <= '0;
            pronto_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            amostra_q <= amostra_d;
            pv_q      <= pv_d;
            for (int unsigned k = 0; k < 10; k++) begin
                acc_q[k] <= acc_d[k];
            end
            dif_q     <= dif_d;
            pronto_q  <= pronto_d;
        end
    end

endmodule

// File: tb/tb_calcula_distancias.sv
// Directed bench for calcula_distancias: a 4-element instance for frame/protocol
// behaviour and an 8-bit accumulator instance for saturation.
module tb_calcula_distancias;

    logic         clock = 1'b0;
    logic         reset;
    logic         inicio;
    logic [7:0]   amostra;
    logic         amostra_valida;
    logic         amostra_pronta;
    logic [1:0]   template_addr;
    logic [79:0]  template_dados;
    logic [159:0] diferencas;
    logic         pronto;
    logic         ocupado;

    logic         s_inicio;
    logic [7:0]   s_amostra;
    logic         s_valida;
    logic         s_pronta;
    logic [1:0]   s_addr;
    logic [79:0]  s_dados;
    logic [79:0]  s_dif;
    logic         s_pronto;
    logic         s_ocupado;

    int nvec = 0;
    int nerr = 0;

    always #5 clock = ~clock;

    calcula_distancias #(.N_ELEM(4), .DATA_W(8), .ACC_W(16), .ADDR_W(2)) dut (
        .clock(clock), .reset(reset), .inicio(inicio), .amostra(amostra),
        .amostra_valida(amostra_valida), .amostra_pronta(amostra_pronta),
        .template_addr(template_addr), .template_dados(template_dados),
        .diferencas(diferencas), .pronto(pronto), .ocupado(ocupado)
    );

    calcula_distancias #(.N_ELEM(4), .DATA_W(8), .ACC_W(8), .ADDR_W(2)) dut_sat (
        .clock(clock), .reset(reset), .inicio(s_inicio), .amostra(s_amostra),
        .amostra_valida(s_valida), .amostra_pronta(s_pronta),
        .template_addr(s_addr), .template_dados(s_dados),
        .diferencas(s_dif), .pronto(s_pronto), .ocupado(s_ocupado)
    );

    // Synchronous ROMs: digit k holds 10*k everywhere; saturation ROM holds 0 for digits 0-4, 255 for 5-9.
    always @(posedge clock) begin
        for (int k = 0; k < 10; k++) begin
            template_dados[k*8 +: 8] <= 8'(10 * k);
            s_dados[k*8 +: 8]        <= (k < 5) ? 8'd0 : 8'd255;
        end
    end

    typedef int arr10_t[10];

    function automatic logic [159:0] pack16(input arr10_t v);
        logic [159:0] r;
        r = '0;
        for (int k = 0; k < 10; k++) r[k*16 +: 16] = 16'(v[k]);
        return r;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_frame(input logic [7:0] samp, input logic [6:0] pat, input int patlen,
                             input logic [159:0] old_dif, input logic [159:0] new_dif,
                             input bit poke);
        int acc;
        int cyc;
        amostra = samp;
        inicio  = 1'b1;
        tick();
        inicio  = 1'b0;
        chk("busy_start", ocupado, 1);
        acc = 0;
        cyc = 0;
        while (acc < 4 && cyc < 50) begin
            amostra_valida = (cyc < patlen) ? pat[cyc] : 1'b1;
            if (poke && cyc == 1) inicio = 1'b1;
            chk("addr", template_addr, acc);
            chk("ready_acc", amostra_pronta, 1);
            chk("hold_dif", diferencas, old_dif);
            if (amostra_pronta && amostra_valida) acc++;
            tick();
            inicio = 1'b0;
            cyc++;
        end
        chk("accepts", acc, 4);
        amostra_valida = 1'b1;
        chk("drena_ready", amostra_pronta, 0);
        chk("drena_pronto", pronto, 0);
        chk("drena_busy", ocupado, 1);
        chk("drena_dif", diferencas, old_dif);
        tick();
        chk("fim_ready", amostra_pronta, 0);
        chk("fim_pronto", pronto, 0);
        chk("fim_busy", ocupado, 1);
        chk("fim_dif", diferencas, old_dif);
        if (poke) inicio = 1'b1;
        tick();
        inicio = 1'b0;
        chk("done_pronto", pronto, 1);
        chk("done_busy", ocupado, 0);
        chk("done_ready", amostra_pronta, 0);
        chk("done_dif", diferencas, new_dif);
        tick();
        chk("after_pronto", pronto, 0);
        chk("after_busy", ocupado, 0);
        chk("after_dif", diferencas, new_dif);
        amostra_valida = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        arr10_t e20;
        arr10_t e50;
        logic [159:0] f20;
        logic [159:0] f50;
        e20 = '{80, 40, 0, 40, 80, 120, 160, 200, 240, 280};
        e50 = '{200, 160, 120, 80, 40, 0, 40, 80, 120, 160};
        f20 = pack16(e20);
        f50 = pack16(e50);

        reset = 1'b1; inicio = 1'b0; amostra = '0; amostra_valida = 1'b0;
        s_inicio = 1'b0; s_amostra = '0; s_valida = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_dif", diferencas, 0);
        chk("rst_pronto", pronto, 0);
        chk("rst_busy", ocupado, 0);
        chk("rst_ready", amostra_pronta, 0);
        chk("rst_sat_dif", s_dif, 0);

        amostra_valida = 1'b1;
        amostra = 8'd20;
        repeat (3) tick();
        chk("idle_busy", ocupado, 0);
        chk("idle_ready", amostra_pronta, 0);
        chk("idle_pronto", pronto, 0);
        amostra_valida = 1'b0;

        run_frame(8'd20, 7'b0, 0, '0, f20, 1'b0);
        run_frame(8'd20, 7'b1101001, 7, f20, f20, 1'b0);
        run_frame(8'd50, 7'b0, 0, f20, f50, 1'b1);

        inicio = 1'b1;
        amostra = 8'd99;
        tick();
        inicio = 1'b0;
        amostra_valida = 1'b1;
        repeat (2) tick();
        reset = 1'b1;
        amostra_valida = 1'b0;
        tick();
        chk("midrst_busy", ocupado, 0);
        chk("midrst_ready", amostra_pronta, 0);
        chk("midrst_dif", diferencas, 0);
        chk("midrst_addr", template_addr, 0);
        reset = 1'b0;
        tick();
        run_frame(8'd20, 7'b0, 0, '0, f20, 1'b0);

        s_amostra = 8'd255;
        s_valida  = 1'b1;
        s_inicio  = 1'b1;
        tick();
        s_inicio  = 1'b0;
        for (int i = 0; i < 40 && !s_pronto; i++) tick();
        chk("sat_done", s_pronto, 1);
        chk("sat_dif", s_dif, 80'h0000000000FFFFFFFFFF);
        s_valida = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
